// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bridge-attached 8N1 UART transmitter with a TX FIFO,
// programmable bit divisor and a level interrupt on "all data sent".
module uart_tx_dev #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // STATUS count field is only 4 bits wide; deeper FIFOs saturate at 15
    function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
        logic [31:0] wide;
        wide = 32'(c);
        if (wide > 32'd15) begin
            sat_count = 4'hF;
        end else begin
            sat_count = wide[3:0];
        end
    endfunction

    state_t      state_q, state_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] frame_div_q, frame_div_d;
    logic [15:0] div_reg_q, div_reg_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;
    logic        irq_q, irq_d;
    logic        txd_q, txd_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        we_data_s, we_status_s, we_ctrl_s, we_div_s;
    logic        full_s, empty_s, busy_s, pop_s, push_ok_s;
    logic [15:0] eff_div_s;
    logic        unused_bits_s;

    assign we_data_s   = WE && (Addr[1:0] == 2'd0);
    assign we_status_s = WE && (Addr[1:0] == 2'd1);
    assign we_ctrl_s   = WE && (Addr[1:0] == 2'd2);
    assign we_div_s    = WE && (Addr[1:0] == 2'd3);
    assign full_s      = (count_q == CW'(FIFO_DEPTH));
    assign empty_s     = (count_q == CW'(0));
    assign busy_s      = (state_q != ST_IDLE);
    // A zero divisor would stall the bit timer, so it behaves as one cycle per bit
    assign eff_div_s   = (div_reg_q == 16'd0) ? 16'd1 : div_reg_q;
    // Only the low address bits and low data bits carry meaning
    assign unused_bits_s = ^{Addr[29:2], Din[31:16]};

    assign IRQ = irq_q;
    assign txd = txd_q;

    // Serialiser: pop a byte when enabled, then time start, 8 data and stop bits
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        bidx_d      = bidx_q;
        shift_d     = shift_q;
        frame_div_d = frame_div_q;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0] && !empty_s) begin
                    pop_s       = 1'b1;
                    shift_d     = mem_q[rd_ptr_q];
                    frame_div_d = eff_div_s;
                    bcnt_d      = eff_div_s - 16'd1;
                    state_d     = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bcnt_q == 16'd0) begin
                    bcnt_d  = frame_div_q - 16'd1;
                    bidx_d  = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    bcnt_d = bcnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bcnt_q == 16'd0) begin
                    bcnt_d  = frame_div_q - 16'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bidx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bcnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    bcnt_d = bcnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serial line level follows the state being entered so txd is a clean flop output
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_IDLE:  txd_d = 1'b1;
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            ST_STOP:  txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping; a push into a full FIFO survives only if a pop frees a slot
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        push_ok_s = we_data_s && (!full_s || pop_s);
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = Din[7:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (we_status_s) begin
            ovf_d = 1'b0;
        end else if (we_data_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control/divisor register writes and the registered interrupt level
    always_comb begin
        ctrl_d    = ctrl_q;
        div_reg_d = div_reg_q;
        if (we_ctrl_s) begin
            ctrl_d = Din[1:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        if (we_div_s) begin
            div_reg_d = Din[15:0];
        end else begin
            div_reg_d = div_reg_q;
        end
        irq_d = ctrl_q[1] && empty_s && !busy_s;
    end

    // Combinational register read mux; reads never change state
    always_comb begin
        Dout = 32'd0;
        case (Addr[1:0])
            2'd0:    Dout = 32'd0;
            2'd1:    Dout = {24'd0, sat_count(count_q), ovf_q, busy_s, empty_s, full_s};
            2'd2:    Dout = {30'd0, ctrl_q};
            2'd3:    Dout = {16'd0, div_reg_q};
            default: Dout = 32'd0;
        endcase
    end

    // State registers; reset drops the line high at once and discards queued bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= 16'd0;
            bidx_q      <= 3'd0;
            shift_q     <= 8'd0;
            frame_div_q <= 16'd1;
            div_reg_q   <= DIV_RESET;
            ctrl_q      <= 2'd0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            txd_q       <= 1'b1;
            wr_ptr_q    <= PW'(0);
            rd_ptr_q    <= PW'(0);
            count_q     <= CW'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            bidx_q      <= bidx_d;
            shift_q     <= shift_d;
            frame_div_q <= frame_div_d;
            div_reg_q   <= div_reg_d;
            ctrl_q      <= ctrl_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
            txd_q       <= txd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed and randomized checks of the UART TX peripheral
// against a timeline model built from frame arithmetic.
module tb_uart_tx_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int checks = 0;
    int errors = 0;

    logic [7:0] fb [0:7];

    uart_tx_dev #(.FIFO_DEPTH(8), .DIV_RESET(16'd16)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(Dout), .IRQ(IRQ), .txd(txd)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Absolute time guard so the run always ends
    initial begin
        #3000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        WE   = 1'b0;
        Addr = {28'd0, a};
        #1;
        chk(tag, Dout, exp);
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Push m bytes from fb on consecutive edges (k=0..m-1), optionally write DIV at edge dwk,
    // then compare txd, IRQ and STATUS every cycle against the expected frame timeline.
    // Frame i starts at edge s[i]; it lasts 10*fd[i] cycles, then one idle cycle precedes the next.
    task automatic frames(input int m, input int d0, input int dwk, input int dnew,
                          input bit irq_en, input string tag);
        int s [0:7];
        int fd [0:7];
        int cur;
        int tend;
        int prev_len;
        bit prev_busy;
        cur = 1;
        for (int i = 0; i < m; i++) begin
            fd[i] = (dwk >= 0 && cur > dwk) ? eff(dnew) : eff(d0);
            s[i]  = cur;
            cur   = cur + 10 * fd[i] + 1;
        end
        tend      = cur + 2;
        prev_len  = 0;
        prev_busy = 1'b0;
        for (int k = 0; k <= tend; k++) begin
            bit   wrote;
            bit   busy;
            logic exp_txd;
            int   len;
            int   pops;
            wrote = 1'b0;
            if (k < m) begin
                Addr = 30'd0; Din = {24'd0, fb[k]}; WE = 1'b1; wrote = 1'b1;
            end else if (k == dwk) begin
                Addr = 30'd3; Din = 32'(dnew); WE = 1'b1; wrote = 1'b1;
            end else begin
                Addr = 30'd1; WE = 1'b0;
            end
            tick();
            WE = 1'b0;
            busy    = 1'b0;
            exp_txd = 1'b1;
            pops    = 0;
            for (int i = 0; i < m; i++) begin
                if (s[i] <= k) pops++;
                if (k >= s[i] && k < s[i] + 10 * fd[i]) begin
                    int bitn;
                    busy = 1'b1;
                    bitn = (k - s[i]) / fd[i];
                    if (bitn == 0)      exp_txd = 1'b0;
                    else if (bitn == 9) exp_txd = 1'b1;
                    else                exp_txd = fb[i][bitn-1];
                end
            end
            len = ((k + 1 < m) ? k + 1 : m) - pops;
            chk($sformatf("%s_txd_k%0d", tag, k), txd, exp_txd);
            chk($sformatf("%s_irq_k%0d", tag, k), IRQ, irq_en && prev_len == 0 && !prev_busy);
            if (!wrote) begin
                chk($sformatf("%s_status_k%0d", tag, k), Dout,
                    {24'd0, 4'(len), 1'b0, busy, (len == 0), (len == 8)});
            end
            prev_len  = len;
            prev_busy = busy;
        end
    endtask

    initial begin
        int low;
        reset = 1'b1; WE = 1'b0; Addr = 30'd0; Din = 32'd0;
        // Reset state
        #3;
        tick(); tick();
        chk("rst_txd", txd, 1'b1);
        chk("rst_irq", IRQ, 1'b0);
        rd_chk("rst_status", 2'd1, 32'h02);
        rd_chk("rst_div", 2'd3, 32'h10);
        rd_chk("rst_ctrl", 2'd2, 32'h0);
        reset = 1'b0;
        tick();
        rd_chk("data_read", 2'd0, 32'h0);
        // Register widths and IRQ level with nothing to send
        wr(2'd2, 32'hFFFF_FFFE);
        rd_chk("ctrl_mask", 2'd2, 32'h2);
        tick();
        chk("irq_idle_level", IRQ, 1'b1);
        wr(2'd3, 32'hABCD_1234);
        rd_chk("div_mask", 2'd3, 32'h1234);
        wr(2'd2, 32'h0);
        tick();
        chk("irq_off", IRQ, 1'b0);

        // Single 0xA5 frame at 4 cycles/bit
        wr(2'd3, 32'd4);
        wr(2'd2, 32'd1);
        tick(); tick();
        fb[0] = 8'hA5;
        frames(1, 4, -1, 0, 1'b0, "a5");

        // Overflow: 9 pushes with transmit disabled
        wr(2'd2, 32'd0);
        for (int i = 0; i < 9; i++) wr(2'd0, 32'(i + 8'h30));
        rd_chk("ovf_status", 2'd1, 32'h89);
        chk("ovf_txd_idle", txd, 1'b1);
        wr(2'd1, 32'hDEAD_BEEF);
        rd_chk("ovf_cleared", 2'd1, 32'h81);
        reset = 1'b1; #1; reset = 1'b0;
        rd_chk("flush_status", 2'd1, 32'h02);
        tick();

        // Back-to-back frames with interrupt enabled
        wr(2'd3, 32'd2);
        wr(2'd2, 32'd3);
        tick(); tick();
        fb[0] = 8'h00; fb[1] = 8'hFF;
        frames(2, 2, -1, 0, 1'b1, "b2b");

        // DIV rewritten mid-frame only affects the following frame
        wr(2'd2, 32'd1);
        tick(); tick();
        fb[0] = 8'h3C; fb[1] = 8'hC3;
        frames(2, 2, 3, 8, 1'b0, "middiv");

        // Randomized frames, divisors (including 0) and mid-run DIV writes
        for (int r = 0; r < 6; r++) begin
            int m, d0, dwk, dnew;
            bit ie;
            m    = int'($urandom_range(1, 4));
            d0   = int'($urandom_range(0, 3));
            dnew = int'($urandom_range(0, 3));
            ie   = 1'($urandom_range(0, 1));
            dwk  = ($urandom_range(0, 1) == 1) ? m + int'($urandom_range(0, 4)) : -1;
            for (int i = 0; i < m; i++) fb[i] = 8'($urandom);
            wr(2'd3, 32'(d0));
            wr(2'd2, {30'd0, ie, 1'b1});
            tick(); tick();
            frames(m, d0, dwk, dnew, ie, $sformatf("rnd%0d", r));
        end

        // Reset during data bit 3 of a 0x00 frame with a second byte queued
        wr(2'd3, 32'd4);
        wr(2'd2, 32'd1);
        tick(); tick();
        wr(2'd0, 32'h00);
        wr(2'd0, 32'hFF);
        repeat (17) tick();
        chk("pre_rst_bit3", txd, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_mid_txd", txd, 1'b1);
        chk("rst_mid_irq", IRQ, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        rd_chk("post_rst_status", 2'd1, 32'h02);
        rd_chk("post_rst_ctrl", 2'd2, 32'h0);
        wr(2'd2, 32'd1);
        low = 0;
        repeat (30) begin
            tick();
            if (txd !== 1'b1) low++;
        end
        chk("no_residual", 32'(low), 32'd0);
        rd_chk("final_status", 2'd1, 32'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
